track_clean_arbiter: RTL and testbench

TRACK_CLEAN_ARBITER -- requirements
Module: track_clean_arbiter

---
 rtl/track_clean_arbiter.sv | 152 +++++++++++++++
 tb/tb_track_clean_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/track_clean_arbiter.sv
// Round-robin track arbiter feeding the clean stage, with a per-event grant budget and BX counter.
// Optional CLEAN_ARB_STATS_EN adds saturating grant/drop counters; DONE_STAGES defaults to `TMUX.

`ifndef TMUX
`define TMUX 3
`endif

module track_clean_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DATA_W      = 126,
    parameter int unsigned BUDGET      = 40,
    parameter int unsigned DONE_STAGES = `TMUX
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              start,
    output logic [1:0]              done,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_read,
    output logic [DATA_W-1:0]       data_out,
    output logic                    enable,
    output logic [2:0]              bx,
    output logic                    truncated
`ifdef CLEAN_ARB_STATS_EN
    ,
    output logic [15:0]             trk_total,
    output logic [7:0]              drop_events
`endif
);

    localparam int unsigned PTR_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(BUDGET + 1);
    localparam logic [CNT_W-1:0] BudgetC = CNT_W'(BUDGET);
    localparam logic [PTR_W-1:0] LastReq = PTR_W'(N_REQ - 1);

    typedef enum logic {StIdle, StRun} state_t;

    state_t           state_q;
    logic [PTR_W-1:0] ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] cand;
    logic             gnt_found;
    logic             can_grant;
    logic             grant;
    logic [DATA_W-1:0] slices [N_REQ];
    logic [1:0]       done_pipe [DONE_STAGES];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign slices[i] = req_data[i*DATA_W +: DATA_W];
    end

    // First valid requester at or after the pointer, searching upward with wrap.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = PTR_W'((32'(ptr_q) + k) % N_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign can_grant = (state_q == StRun) && (count_q < BudgetC) && (start == 2'b00);

    always_comb begin
        req_read = '0;
        if (can_grant && gnt_found) begin
            req_read[gnt_idx] = 1'b1;
        end
    end

    assign grant = |req_read;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            bx        <= 3'b111;
            ptr_q     <= '0;
            count_q   <= '0;
            truncated <= 1'b0;
            enable    <= 1'b0;
            data_out  <= '0;
        end else if (start[1]) begin
            state_q   <= StIdle;
            bx        <= 3'b111;
            ptr_q     <= '0;
            count_q   <= '0;
            truncated <= 1'b0;
            enable    <= 1'b0;
            data_out  <= '0;
        end else if (start[0]) begin
            state_q   <= StRun;
            bx        <= bx + 3'd1;
            count_q   <= '0;
            truncated <= 1'b0;
            enable    <= 1'b0;
            data_out  <= '0;
        end else begin
            enable   <= grant;
            data_out <= grant ? slices[gnt_idx] : '0;
            if (grant) begin
                ptr_q   <= (gnt_idx == LastReq) ? '0 : gnt_idx + PTR_W'(1);
                count_q <= count_q + CNT_W'(1);
            end
            // Only flag truncation when work was actually left on the table.
            if (state_q == StRun && count_q == BudgetC && |req_valid) begin
                truncated <= 1'b1;
            end
        end
    end

    // A sync reset flushes in-flight done bits but still carries its own start word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < DONE_STAGES; k++) begin
                done_pipe[k] <= 2'b00;
            end
        end else begin
            done_pipe[0] <= start;
            for (int unsigned k = 1; k < DONE_STAGES; k++) begin
                done_pipe[k] <= start[1] ? 2'b00 : done_pipe[k-1];
            end
        end
    end

    assign done = done_pipe[DONE_STAGES-1];

`ifdef CLEAN_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trk_total   <= '0;
            drop_events <= '0;
        end else if (start[1]) begin
            trk_total   <= '0;
            drop_events <= '0;
        end else begin
            if (grant && trk_total != 16'hFFFF) begin
                trk_total <= trk_total + 16'd1;
            end
            if (start[0] && truncated && drop_events != 8'hFF) begin
                drop_events <= drop_events + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_track_clean_arbiter.sv
// Directed self-checking bench for track_clean_arbiter (default 4 requesters, budget 40).

module tb_track_clean_arbiter;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned DATA_W = 126;
    localparam int unsigned BUDGET = 40;
    localparam int unsigned DS     = 3;

    logic                    clk;
    logic                    reset;
    logic [1:0]              start;
    logic [1:0]              done;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_read;
    logic [DATA_W-1:0]       data_out;
    logic                    enable;
    logic [2:0]              bx;
    logic                    truncated;
`ifdef CLEAN_ARB_STATS_EN
    logic [15:0]             trk_total;
    logic [7:0]              drop_events;
`endif

    int checks;
    int errors;

    track_clean_arbiter #(
        .N_REQ      (N_REQ),
        .DATA_W     (DATA_W),
        .BUDGET     (BUDGET),
        .DONE_STAGES(DS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .done       (done),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_read   (req_read),
        .data_out   (data_out),
        .enable     (enable),
        .bx         (bx),
        .truncated  (truncated)
`ifdef CLEAN_ARB_STATS_EN
        ,
        .trk_total  (trk_total),
        .drop_events(drop_events)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [DATA_W-1:0] word(input int i, input int tag);
        logic [DATA_W-1:0] w;
        w = '0;
        w[DATA_W-1 -: 8] = 8'(8'hA0 + i);
        w[31:0] = 32'(tag * 16 + i);
        return w;
    endfunction

    task automatic set_data(input int tag);
        for (int i = 0; i < int'(N_REQ); i++) begin
            req_data[i*DATA_W +: DATA_W] = word(i, tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 2'b01;
        tick();
        start = 2'b00;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 2'b00;
        req_valid = 4'hF;
        set_data(0);
        #12;
        checks++; if (bx !== 3'b111) begin errors++; $display("FAIL reset_bx got=%b want=111", bx); end
        checks++; if (enable !== 1'b0 || data_out !== '0) begin errors++;
            $display("FAIL reset_out enable=%b data_out=%h want 0", enable, data_out); end
        checks++; if (req_read !== 4'b0000) begin errors++; $display("FAIL reset_read got=%b want=0000", req_read); end
        checks++; if (done !== 2'b00 || truncated !== 1'b0) begin errors++;
            $display("FAIL reset_flags done=%b truncated=%b want 00/0", done, truncated); end
        reset = 1'b1;
        tick();
        req_valid = 4'h0;
        checks++; if (req_read !== 4'b0000) begin errors++; $display("FAIL idle_read got=%b want=0000", req_read); end
    endtask

    task automatic test_start_bx();
        pulse_start();
        checks++; if (bx !== 3'd0) begin errors++; $display("FAIL bx_first got=%0d want=0", bx); end
        checks++; if (enable !== 1'b0 || data_out !== '0 || truncated !== 1'b0) begin errors++;
            $display("FAIL start_out enable=%b truncated=%b want 0", enable, truncated); end
        req_valid = 4'b0001;
        #1;
        checks++; if (req_read !== 4'b0001) begin errors++; $display("FAIL run_state read=%b want=0001", req_read); end
        req_valid = 4'b0000;
        pulse_start();
        checks++; if (bx !== 3'd1) begin errors++; $display("FAIL bx_second got=%0d want=1", bx); end
        for (int i = 0; i < 8; i++) pulse_start();
        checks++; if (bx !== 3'd1) begin errors++; $display("FAIL bx_wrap got=%0d want=1", bx); end
    endtask

    task automatic test_budget();
        logic [N_REQ-1:0] exp_rd;
        pulse_start();
        checks++; if (bx !== 3'd2) begin errors++; $display("FAIL budget_bx got=%0d want=2", bx); end
        set_data(1);
        req_valid = 4'hF;
        #1;
        for (int k = 0; k < int'(BUDGET); k++) begin
            exp_rd = 4'b0001 << (k % 4);
            checks++; if (req_read !== exp_rd) begin errors++;
                $display("FAIL budget_read k=%0d got=%b want=%b", k, req_read, exp_rd); end
            tick();
            checks++; if (enable !== 1'b1 || data_out !== word(k % 4, 1)) begin errors++;
                $display("FAIL budget_data k=%0d enable=%b data_out=%h want=%h", k, enable, data_out,
                         word(k % 4, 1)); end
        end
        checks++; if (req_read !== 4'b0000) begin errors++; $display("FAIL budget_41st got=%b want=0000", req_read); end
        tick();
        checks++; if (enable !== 1'b0 || data_out !== '0) begin errors++;
            $display("FAIL budget_stop enable=%b data_out=%h want 0", enable, data_out); end
        checks++; if (truncated !== 1'b1) begin errors++; $display("FAIL budget_trunc got=%b want=1", truncated); end
        req_valid = 4'h0;
    endtask

    task automatic test_truncate_boundary();
        pulse_start();
        checks++; if (bx !== 3'd3 || truncated !== 1'b0) begin errors++;
            $display("FAIL tb_start bx=%0d truncated=%b want 3/0", bx, truncated); end
        req_valid = 4'hF;
        for (int k = 0; k < int'(BUDGET); k++) tick();
        req_valid = 4'h0;
        tick();
        tick();
        checks++; if (truncated !== 1'b0) begin errors++; $display("FAIL trunc_idle got=%b want=0", truncated); end
        req_valid = 4'b0001;
        #1;
        checks++; if (req_read !== 4'b0000) begin errors++; $display("FAIL trunc_noread got=%b want=0000", req_read); end
        tick();
        checks++; if (truncated !== 1'b1) begin errors++; $display("FAIL trunc_set got=%b want=1", truncated); end
        req_valid = 4'h0;
    endtask

    task automatic test_rotate();
        pulse_start();
        checks++; if (bx !== 3'd4 || truncated !== 1'b0) begin errors++;
            $display("FAIL rot_start bx=%0d truncated=%b want 4/0", bx, truncated); end
        set_data(2);
        req_valid = 4'b0111;
        tick();
        tick();
        tick();
        set_data(3);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_read !== 4'b0100) begin errors++; $display("FAIL rot_read got=%b want=0100", req_read); end
        tick();
        checks++; if (enable !== 1'b1 || data_out !== word(2, 3)) begin errors++;
            $display("FAIL rot_data enable=%b data_out=%h want=%h", enable, data_out, word(2, 3)); end
        req_valid = 4'b0000;
        #1;
        checks++; if (req_read !== 4'b0000) begin errors++; $display("FAIL rot_none got=%b want=0000", req_read); end
        tick();
        checks++; if (enable !== 1'b0 || data_out !== '0) begin errors++;
            $display("FAIL rot_gap enable=%b data_out=%h want 0", enable, data_out); end
    endtask

    task automatic test_sync_reset();
        pulse_start();
        checks++; if (bx !== 3'd5) begin errors++; $display("FAIL sr_bx got=%0d want=5", bx); end
        req_valid = 4'hF;
        tick();
        tick();
        checks++; if (done !== 2'b01) begin errors++; $display("FAIL done_pulse got=%b want=01", done); end
        start = 2'b11;
        #1;
        checks++; if (req_read !== 4'b0000) begin errors++; $display("FAIL sr_noread got=%b want=0000", req_read); end
        tick();
        start = 2'b00;
        #1;
        checks++; if (bx !== 3'b111 || truncated !== 1'b0) begin errors++;
            $display("FAIL sr_state bx=%b truncated=%b want 111/0", bx, truncated); end
        checks++; if (enable !== 1'b0 || data_out !== '0 || req_read !== 4'b0000) begin errors++;
            $display("FAIL sr_out enable=%b read=%b want 0", enable, req_read); end
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL sr_done0 got=%b want=00", done); end
        tick();
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL sr_done1 got=%b want=00", done); end
        tick();
        checks++; if (done !== 2'b11) begin errors++; $display("FAIL sr_done2 got=%b want=11", done); end
        tick();
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL sr_done3 got=%b want=00", done); end
        req_valid = 4'h0;
    endtask

    task automatic test_async_reset();
        req_valid = 4'hF;
        pulse_start();
        checks++; if (bx !== 3'd0) begin errors++; $display("FAIL ar_bx0 got=%0d want=0", bx); end
        tick();
        checks++; if (enable !== 1'b1) begin errors++; $display("FAIL ar_pre enable=%b want=1", enable); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (enable !== 1'b0 || data_out !== '0) begin errors++;
            $display("FAIL ar_out enable=%b data_out=%h want 0", enable, data_out); end
        checks++; if (bx !== 3'b111 || req_read !== 4'b0000 || done !== 2'b00) begin errors++;
            $display("FAIL ar_state bx=%b read=%b done=%b want 111/0000/00", bx, req_read, done); end
        #1;
        reset = 1'b1;
        req_valid = 4'h0;
        tick();
        pulse_start();
        checks++; if (bx !== 3'd0) begin errors++; $display("FAIL ar_bx_after got=%0d want=0", bx); end
    endtask

`ifdef CLEAN_ARB_STATS_EN
    task automatic test_stats();
        start = 2'b10;
        tick();
        start = 2'b00;
        checks++; if (trk_total !== 16'd0 || drop_events !== 8'd0) begin errors++;
            $display("FAIL stats_clear trk=%0d drop=%0d want 0/0", trk_total, drop_events); end
        req_valid = 4'hF;
        for (int e = 0; e < 3; e++) begin
            pulse_start();
            if (e == 2) begin
                checks++; if (drop_events !== 8'd2) begin errors++;
                    $display("FAIL stats_drop got=%0d want=2", drop_events); end
            end
            for (int k = 0; k < 50; k++) tick();
        end
        checks++; if (trk_total !== 16'd120) begin errors++;
            $display("FAIL stats_total got=%0d want=120", trk_total); end
        req_valid = 4'h0;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_start_bx();
        test_budget();
        test_truncate_boundary();
        test_rotate();
        test_sync_reset();
        test_async_reset();
`ifdef CLEAN_ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
